joystick_dir: RTL and testbench
===============================

// Module: joystick_dir
// PURPOSE
//  Input-side reader for the board's five-way direction switch (N/E/S/W/CENTRE),
//  i.e. the counterpart of the LED direction outputs. Synchronises and debounces
//  the raw pads, emits one-cycle press pulses and keeps the snake heading.
//  A new heading is committed only on the game-step strobe. A reversal onto the
//  snake's own body is rejected. Sits between the top-level pads and the game FSM.
// PARAMETERS
//  DEBOUNCE_CYCLES  250000  clocks a synchronised input must differ from stable state before accepted (>=1)
//  CNT_W            18      debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  asynchronous active-low reset
//  BTN_N        in   1  raw pad, active-low (0 = pressed), asynchronous to clk
//  BTN_E        in   1  raw pad, active-low
//  BTN_S        in   1  raw pad, active-low
//  BTN_W        in   1  raw pad, active-low
//  BTN_CENTRE   in   1  raw pad, active-low
//  tick         in   1  one-cycle game-step strobe from divider
//  pressed      out  5  debounced levels, active-high {CENTRE,W,S,E,N} = bits [4:0]
//  press_pulse  out  5  one-cycle pulse on each 0->1 of pressed[i]
//  dir          out  2  committed heading: 0=N 1=E 2=S 3=W
//  dir_changed  out  1  one-cycle pulse, cycle after a tick that changed dir
//  pause_toggle out  1  = press_pulse[4] (centre press), registered with it
// BEHAVIOUR
//  Reset (async assert, sync-free release): sync flops = 1 (released), pressed=0,
//   press_pulse=0, counters=0, dir=0 (N), pending=0 (N), dir_changed=0, pause_toggle=0.
//  Sync: 2-flop synchroniser per pad, then inverted to active-high s[i].
//  Debounce per bit i, state stable[i] (= pressed[i]), counter cnt[i]:
//   - s[i]==stable[i]: cnt<=0.
//   - s[i]!=stable[i] and cnt<DEBOUNCE_CYCLES-1: cnt<=cnt+1.
//   - s[i]!=stable[i] and cnt==DEBOUNCE_CYCLES-1: stable<=s[i], cnt<=0.
//   - Any single-cycle return to stable clears cnt (glitch rejected).
//   - Latency: pressed[i] changes exactly DEBOUNCE_CYCLES+2 clocks after the first
//     edge sampling the new pad level, if held throughout. Same for release.
//  press_pulse[i] high for exactly the clock after pressed[i] goes 0->1. No pulse on release.
//  Held button: one pulse only.
//  Heading: pending register, updated from press_pulse[3:0]:
//   - Candidate = lowest-index set bit (priority N>E>S>W when simultaneous).
//   - Accepted iff candidate != (dir ^ 2'b10). Checked against committed dir,
//     not pending; rejected presses leave pending unchanged.
//   - Later accepted presses before a tick overwrite pending (last wins).
//  On tick: dir<=pending. dir_changed<=1 next cycle iff new value != old dir.
//  tick and press_pulse same cycle: tick commits old pending; the press updates
//   pending for the next tick.
//  Centre never affects heading. pause_toggle mirrors press_pulse[4].
//  rst_n asserted mid-debounce or mid-pulse: all state returns to reset values
//   immediately. No pulse is emitted on release of reset even if a pad is held;
//   a held pad is re-debounced from cnt=0.
// TESTING (DEBOUNCE_CYCLES=4)
//  1. Reset, all pads high -> pressed=0, dir=0, no pulses for 100 clocks.
//  2. BTN_E low held -> pressed[1] rises at clock 6. press_pulse[1] for 1 clock.
//     Next tick -> dir=1, dir_changed=1 for 1 clock.
//  3. BTN_S low for 3 clocks then high, repeated -> pressed stays 0, no pulse.
//  4. dir=0 (N), press S then tick -> dir stays 0, dir_changed=0.
//     Press E then S before one tick -> dir=1 after tick.
//  5. N and W debounced in same cycle, dir=1 -> pending=N. Tick -> dir=0.
//     Tick coincident with a new W press pulse -> commits previous pending; W on the following tick.
//  6. Hold CENTRE, pulse rst_n low at clock 3 of debounce -> all outputs 0.
//     Pressed rises 6 clocks after release. Single pause_toggle pulse.

Source files
------------

// File: rtl/joystick_dir.sv
// Five-way direction switch reader: synchronise, debounce, press pulses and snake heading.
// Heading changes are committed on the game-step strobe; reversals onto the body are dropped.
module joystick_dir #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       BTN_N,
  input  logic       BTN_E,
  input  logic       BTN_S,
  input  logic       BTN_W,
  input  logic       BTN_CENTRE,
  input  logic       tick,
  output logic [4:0] pressed,
  output logic [4:0] press_pulse,
  output logic [1:0] dir,
  output logic       dir_changed,
  output logic       pause_toggle
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [4:0]       w_raw;
  logic [4:0]       w_s;
  logic [4:0]       r_sync1;
  logic [4:0]       r_sync2;
  logic [4:0]       r_stable;
  logic [4:0]       w_stable_d;
  logic [CNT_W-1:0] r_cnt   [5];
  logic [CNT_W-1:0] w_cnt_d [5];
  logic [4:0]       r_pulse;
  logic [1:0]       r_dir;
  logic [1:0]       r_pending;
  logic             r_changed;
  logic [1:0]       w_cand;
  logic             w_cand_vld;
  logic             w_accept;

  assign w_raw = {BTN_CENTRE, BTN_W, BTN_S, BTN_E, BTN_N};
  assign w_s   = ~r_sync2;

  // Sync flops reset to the released (high) pad level so reset release never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_stable_d = r_stable;
    for (int i = 0; i < 5; i++) begin
      w_cnt_d[i] = '0;
      if (w_s[i] != r_stable[i]) begin
        if (r_cnt[i] == CntMax) begin
          w_stable_d[i] = w_s[i];
        end else begin
          w_cnt_d[i] = r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= '0;
      r_pulse  <= '0;
      for (int i = 0; i < 5; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_stable <= w_stable_d;
      r_pulse  <= w_stable_d & ~r_stable;
      for (int i = 0; i < 5; i++) begin
        r_cnt[i] <= w_cnt_d[i];
      end
    end
  end

  // Lowest index wins on simultaneous presses (N > E > S > W).
  always_comb begin
    w_cand     = 2'd0;
    w_cand_vld = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (r_pulse[i]) begin
        w_cand     = 2'(i);
        w_cand_vld = 1'b1;
      end
    end
  end

  assign w_accept = w_cand_vld && (w_cand != (r_dir ^ 2'b10));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir     <= 2'd0;
      r_pending <= 2'd0;
      r_changed <= 1'b0;
    end else begin
      r_changed <= tick && (r_pending != r_dir);
      if (tick) begin
        r_dir <= r_pending;
      end
      if (w_accept) begin
        r_pending <= w_cand;
      end
    end
  end

  assign pressed      = r_stable;
  assign press_pulse  = r_pulse;
  assign dir          = r_dir;
  assign dir_changed  = r_changed;
  assign pause_toggle = r_pulse[4];

endmodule

// File: tb/tb_joystick_dir.sv
// Directed bench for joystick_dir with DEBOUNCE_CYCLES=4: latency, glitches, heading rules, reset.
module tb_joystick_dir;

  logic       clk;
  logic       rst_n;
  logic [4:0] pads_n;
  logic       tick;
  logic [4:0] pressed;
  logic [4:0] press_pulse;
  logic [1:0] dir;
  logic       dir_changed;
  logic       pause_toggle;

  int errors = 0;
  int checks = 0;

  joystick_dir #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .BTN_N       (pads_n[0]),
    .BTN_E       (pads_n[1]),
    .BTN_S       (pads_n[2]),
    .BTN_W       (pads_n[3]),
    .BTN_CENTRE  (pads_n[4]),
    .tick        (tick),
    .pressed     (pressed),
    .press_pulse (press_pulse),
    .dir         (dir),
    .dir_changed (dir_changed),
    .pause_toggle(pause_toggle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [4:0] mask;
    logic       do_tick;
    logic [1:0] exp_dir;
    logic       exp_chg;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Press the buttons in mask, hold until debounced, then release and let the release settle.
  task automatic press_release(input logic [4:0] mask, output logic [4:0] seen, output int pcnt);
    seen   = '0;
    pcnt   = 0;
    pads_n = ~mask;
    for (int c = 0; c < 18; c++) begin
      if (c == 8) pads_n = '1;
      @(negedge clk);
      seen |= press_pulse;
      if (pause_toggle) pcnt++;
    end
  endtask

  task automatic do_tick;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  logic [4:0] seen;
  int         pcnt;

  initial begin
    vecs[0]  = '{5'b00001, 1'b1, 2'd0, 1'b1};
    vecs[1]  = '{5'b00100, 1'b1, 2'd0, 1'b0};
    vecs[2]  = '{5'b00010, 1'b0, 2'd0, 1'b0};
    vecs[3]  = '{5'b00100, 1'b1, 2'd1, 1'b1};
    vecs[4]  = '{5'b01000, 1'b1, 2'd1, 1'b0};
    vecs[5]  = '{5'b01001, 1'b1, 2'd0, 1'b1};
    vecs[6]  = '{5'b10000, 1'b1, 2'd0, 1'b0};
    vecs[7]  = '{5'b01000, 1'b1, 2'd3, 1'b1};
    vecs[8]  = '{5'b00010, 1'b1, 2'd3, 1'b0};
    vecs[9]  = '{5'b00100, 1'b1, 2'd2, 1'b1};
    vecs[10] = '{5'b01111, 1'b1, 2'd2, 1'b0};
    vecs[11] = '{5'b00010, 1'b0, 2'd2, 1'b0};
    vecs[12] = '{5'b01000, 1'b1, 2'd3, 1'b1};

    rst_n  = 1'b0;
    pads_n = '1;
    tick   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {2'b0, pressed, press_pulse, dir_changed, pause_toggle, dir},
          16'h0000);
    rst_n = 1'b1;

    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      check("idle_quiet", {2'b0, pressed, press_pulse, dir_changed, pause_toggle, dir},
            16'h0000);
    end

    // East held: pressed rises on the 6th edge, one pulse.
    pads_n[1] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("e_latency_pressed", 16'(pressed[1]), 16'(k >= 6));
      check("e_latency_pulse", 16'(press_pulse[1]), 16'(k == 6));
    end
    pads_n[1] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("e_release_no_pulse", 16'(press_pulse), 16'h0);
      check("e_release_latency", 16'(pressed[1]), 16'(k < 6));
    end
    do_tick();
    check("e_tick_dir", 16'(dir), 16'd1);
    check("e_tick_chg", 16'(dir_changed), 16'd1);
    @(negedge clk);
    check("e_chg_one_cycle", 16'(dir_changed), 16'd0);

    // South glitches of 3 clocks never reach the debounced state.
    for (int r = 0; r < 4; r++) begin
      pads_n[2] = 1'b0;
      repeat (3) begin
        @(negedge clk);
        check("glitch_low", {6'b0, pressed, press_pulse}, 16'h0);
      end
      pads_n[2] = 1'b1;
      repeat (3) begin
        @(negedge clk);
        check("glitch_high", {6'b0, pressed, press_pulse}, 16'h0);
      end
    end

    for (int v = 0; v < 13; v++) begin
      press_release(vecs[v].mask, seen, pcnt);
      check($sformatf("vec%0d_pulses", v), 16'(seen), 16'(vecs[v].mask));
      check($sformatf("vec%0d_pause", v), 16'(pcnt), 16'(vecs[v].mask[4]));
      check($sformatf("vec%0d_released", v), 16'(pressed), 16'h0);
      if (vecs[v].do_tick) do_tick();
      check($sformatf("vec%0d_dir", v), 16'(dir), 16'(vecs[v].exp_dir));
      check($sformatf("vec%0d_chg", v), 16'(dir_changed), 16'(vecs[v].exp_chg));
      @(negedge clk);
      check($sformatf("vec%0d_chg_clear", v), 16'(dir_changed), 16'h0);
    end

    // Tick in the same cycle as a W pulse commits the older pending S.
    press_release(5'b00100, seen, pcnt);
    check("coinc_pre_dir", 16'(dir), 16'd3);
    pads_n[3] = 1'b0;
    repeat (6) @(negedge clk);
    check("coinc_w_pulse", 16'(press_pulse[3]), 16'd1);
    do_tick();
    check("coinc_dir_old_pending", 16'(dir), 16'd2);
    check("coinc_chg", 16'(dir_changed), 16'd1);
    pads_n[3] = 1'b1;
    repeat (8) @(negedge clk);
    do_tick();
    check("coinc_next_tick_dir", 16'(dir), 16'd3);
    check("coinc_next_tick_chg", 16'(dir_changed), 16'd1);
    @(negedge clk);

    // Reset mid-debounce of a held centre button.
    pads_n[4] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {2'b0, pressed, press_pulse, dir_changed, pause_toggle, dir},
          16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("rst_redebounce_pressed", 16'(pressed[4]), 16'(k >= 6));
      check("rst_redebounce_pause", 16'(pause_toggle), 16'(k == 6));
      check("rst_redebounce_pulse", 16'(press_pulse), 16'(k == 6 ? 5'b10000 : 5'b00000));
      check("rst_dir", 16'(dir), 16'd0);
    end
    pads_n[4] = 1'b1;
    repeat (8) @(negedge clk);
    check("final_released", {6'b0, pressed, press_pulse}, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
